// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//   Shares one combinational 16-bit logical-left barrel shifter (lshift16)
//   between two requesters: port 0 (execute-stage ALU) and port 1 (multicycle
//   multiply/CSR unit). At most one request is granted per cycle. The granted
//   operand/amount drive the shifter, and the result is captured in a
//   one-entry output register. That register holds its value until the
//   consumer takes it.
//
// Parameters
//   RR_INIT : requester favoured by round-robin after reset (0 or 1)
//   CNT_W   : width of the saturating per-requester grant counters
//
// Ports
//   clk            : system clock, all flops on posedge
//   rst            : synchronous active-high reset
//   req0/src0/amt0 : requester 0 request, operand, shift amount
//   gnt0           : combinational accept for requester 0
//   req1/src1/amt1 : requester 1 request, operand, shift amount
//   gnt1           : combinational accept for requester 1
//   res_vld        : output register holds a valid result
//   res_id         : requester that owns res
//   res            : src << amt, zero fill
//   res_rdy        : consumer takes res this cycle when res_vld=1
//   gcnt0/gcnt1    : saturating grant counts since reset
//
// Configuration macro
//   SHIFT_ARB_FIXED_PRI_EN : when defined, port 0 always wins on contention.
//                            The round-robin pointer flop is removed and
//                            RR_INIT is ignored.
// -----------------------------------------------------------------------------

module lshift16 (
    input  logic [15:0] src_i,
    input  logic [3:0]  amt_i,
    output logic [15:0] res_o
);
    assign res_o = src_i << amt_i;
endmodule

module shift_arbiter #(
    parameter logic        RR_INIT = 1'b0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [15:0]      src0,
    input  logic [3:0]       amt0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [15:0]      src1,
    input  logic [3:0]       amt1,
    output logic             gnt1,
    output logic             res_vld,
    output logic             res_id,
    output logic [15:0]      res,
    input  logic             res_rdy,
    output logic [CNT_W-1:0] gcnt0,
    output logic [CNT_W-1:0] gcnt1
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       res_q, res_d;
    logic              res_id_q, res_id_d;
    logic [CNT_W-1:0]  gcnt0_q, gcnt0_d;
    logic [CNT_W-1:0]  gcnt1_q, gcnt1_d;
    logic              can_accept_s;
    logic              gnt0_s, gnt1_s;
    logic [15:0]       sh_src_s;
    logic [3:0]        sh_amt_s;
    logic [15:0]       sh_res_s;

`ifndef SHIFT_ARB_FIXED_PRI_EN
    logic              ptr_q, ptr_d;
`endif

    // Saturating increment: the counter holds once it reaches all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // A new result can be accepted when the register is empty or being drained.
    assign can_accept_s = (state_q == ST_EMPTY) | res_rdy;

    // Arbitration: lone requests win outright; contention resolved by pointer
    // (or fixed priority in the macro build). Nothing is granted in reset.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (can_accept_s) begin
            case ({req1, req0})
                2'b01: gnt0_s = 1'b1;
                2'b10: gnt1_s = 1'b1;
                2'b11: begin
`ifdef SHIFT_ARB_FIXED_PRI_EN
                    gnt0_s = 1'b1;
`else
                    if (ptr_q) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = 1'b1;
                    end
`endif
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Shifter operand mux: port 1 operands only when port 1 is granted.
    always_comb begin
        sh_src_s = src0;
        sh_amt_s = amt0;
        if (gnt1_s) begin
            sh_src_s = src1;
            sh_amt_s = amt1;
        end else begin
            sh_src_s = src0;
            sh_amt_s = amt0;
        end
    end

    lshift16 u_lshift16 (
        .src_i (sh_src_s),
        .amt_i (sh_amt_s),
        .res_o (sh_res_s)
    );

    // Next-state: output register capture, FSM, counters and RR pointer.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        res_id_d = res_id_q;
        gcnt0_d  = gcnt0_q;
        gcnt1_d  = gcnt1_q;
`ifndef SHIFT_ARB_FIXED_PRI_EN
        ptr_d    = ptr_q;
        // Only a contended grant moves the pointer, always to the other port.
        if (req0 && req1 && (gnt0_s || gnt1_s)) begin
            ptr_d = gnt0_s;
        end else begin
            ptr_d = ptr_q;
        end
`endif
        if (gnt0_s || gnt1_s) begin
            state_d  = ST_FULL;
            res_d    = sh_res_s;
            res_id_d = gnt1_s;
        end else if ((state_q == ST_FULL) && res_rdy) begin
            state_d  = ST_EMPTY;
        end else begin
            state_d  = state_q;
        end
        if (gnt0_s) begin
            gcnt0_d = sat_inc(gcnt0_q);
        end else begin
            gcnt0_d = gcnt0_q;
        end
        if (gnt1_s) begin
            gcnt1_d = sat_inc(gcnt1_q);
        end else begin
            gcnt1_d = gcnt1_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            res_q    <= 16'h0000;
            res_id_q <= 1'b0;
            gcnt0_q  <= {CNT_W{1'b0}};
            gcnt1_q  <= {CNT_W{1'b0}};
`ifndef SHIFT_ARB_FIXED_PRI_EN
            ptr_q    <= RR_INIT;
`endif
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            res_id_q <= res_id_d;
            gcnt0_q  <= gcnt0_d;
            gcnt1_q  <= gcnt1_d;
`ifndef SHIFT_ARB_FIXED_PRI_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign gnt0    = gnt0_s;
    assign gnt1    = gnt1_s;
    assign res_vld = (state_q == ST_FULL);
    assign res_id  = res_id_q;
    assign res     = res_q;
    assign gcnt0   = gcnt0_q;
    assign gcnt1   = gcnt1_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//   Directed, table-driven bench for shift_arbiter (default round-robin build,
//   RR_INIT=0, CNT_W=8). Each table row gives the inputs for one cycle, the
//   expected combinational grants, and the expected registered outputs after
//   the following posedge. Hand-written sequences cover counter saturation and
//   reset while holding a result.
// -----------------------------------------------------------------------------

module tb_shift_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [15:0] src0, src1;
    logic [3:0]  amt0, amt1;
    logic        gnt0, gnt1;
    logic        res_vld, res_id, res_rdy;
    logic [15:0] res;
    logic [7:0]  gcnt0, gcnt1;

    int n_vec;
    int n_chk;
    int n_err;

    shift_arbiter #(.RR_INIT(1'b0), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .src0    (src0),
        .amt0    (amt0),
        .gnt0    (gnt0),
        .req1    (req1),
        .src1    (src1),
        .amt1    (amt1),
        .gnt1    (gnt1),
        .res_vld (res_vld),
        .res_id  (res_id),
        .res     (res),
        .res_rdy (res_rdy),
        .gcnt0   (gcnt0),
        .gcnt1   (gcnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req0;
        logic [15:0] src0;
        logic [3:0]  amt0;
        logic        req1;
        logic [15:0] src1;
        logic [3:0]  amt1;
        logic        rdy;
        logic        g0;
        logic        g1;
        logic        vld;
        logic        id;
        logic [15:0] res;
        logic [7:0]  c0;
        logic [7:0]  c1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic q0, input logic [15:0] s0, input logic [3:0] a0,
        input logic q1, input logic [15:0] s1, input logic [3:0] a1, input logic rd,
        input logic g0, input logic g1, input logic v, input logic id,
        input logic [15:0] rs, input logic [7:0] c0, input logic [7:0] c1);
        vec_t x;
        x.rst = r;   x.req0 = q0; x.src0 = s0; x.amt0 = a0;
        x.req1 = q1; x.src1 = s1; x.amt1 = a1; x.rdy = rd;
        x.g0 = g0;   x.g1 = g1;   x.vld = v;   x.id = id;
        x.res = rs;  x.c0 = c0;   x.c1 = c1;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic q0, input logic [15:0] s0, input logic [3:0] a0,
                         input logic q1, input logic [15:0] s1, input logic [3:0] a1, input logic rd);
        rst = r; req0 = q0; src0 = s0; amt0 = a0;
        req1 = q1; src1 = s1; amt1 = a1; res_rdy = rd;
    endtask

    initial begin
        n_vec = 0;
        n_chk = 0;
        n_err = 0;
        drive(1'b1, 1'b1, 16'h0000, 4'd0, 1'b1, 16'h0000, 4'd0, 1'b0);

        //        rst  q0    src0      a0     q1    src1      a1     rdy   g0    g1    vld   id    res        c0     c1
        // reset with both requests high
        tbl.push_back(mk(1'b1, 1'b1, 16'h0000, 4'd0,  1'b1, 16'h0000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0, 8'd0));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0000, 4'd0,  1'b1, 16'h0000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0, 8'd0));
        // single request on port 0
        tbl.push_back(mk(1'b0, 1'b1, 16'h00F1, 4'd4,  1'b0, 16'h0000, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0F10, 8'd1, 8'd0));
        // drain, result register keeps last data
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 4'd0,  1'b0, 16'h0000, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0F10, 8'd1, 8'd0));
        // contention, 4 cycles: 0,1,0,1
        tbl.push_back(mk(1'b0, 1'b1, 16'h0001, 4'd1,  1'b1, 16'h0003, 4'd2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 8'd2, 8'd0));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0001, 4'd1,  1'b1, 16'h0003, 4'd2,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000C, 8'd2, 8'd1));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0001, 4'd1,  1'b1, 16'h0003, 4'd2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 8'd3, 8'd1));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0001, 4'd1,  1'b1, 16'h0003, 4'd2,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000C, 8'd3, 8'd2));
        // backpressure: FULL, res_rdy low for 3 cycles with req1 pending
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 4'd0,  1'b1, 16'h0005, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000C, 8'd3, 8'd2));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 4'd0,  1'b1, 16'h0005, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000C, 8'd3, 8'd2));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 4'd0,  1'b1, 16'h0005, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000C, 8'd3, 8'd2));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 4'd0,  1'b1, 16'h0005, 4'd3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0028, 8'd3, 8'd3));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 4'd0,  1'b0, 16'h0000, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0028, 8'd3, 8'd3));
        // shift edges
        tbl.push_back(mk(1'b0, 1'b1, 16'h8001, 4'd0,  1'b0, 16'h0000, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8001, 8'd4, 8'd3));
        tbl.push_back(mk(1'b0, 1'b1, 16'h8001, 4'd15, 1'b0, 16'h0000, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8000, 8'd5, 8'd3));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 4'd0,  1'b1, 16'hFFFF, 4'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFF00, 8'd5, 8'd4));
        // lone grants left the pointer at port 0
        tbl.push_back(mk(1'b0, 1'b1, 16'h1234, 4'd4,  1'b1, 16'h0007, 4'd1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h2340, 8'd6, 8'd4));
        // reset while FULL: result discarded, counters cleared
        tbl.push_back(mk(1'b1, 1'b1, 16'h0001, 4'd0,  1'b1, 16'h0001, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0, 8'd0));
        // pointer back at RR_INIT after reset
        tbl.push_back(mk(1'b0, 1'b1, 16'h0001, 4'd0,  1'b1, 16'h0002, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 8'd1, 8'd0));
        // FULL, not ready: hold, no grants
        tbl.push_back(mk(1'b0, 1'b1, 16'h0001, 4'd0,  1'b1, 16'h0002, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 8'd1, 8'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].req0, tbl[i].src0, tbl[i].amt0,
                  tbl[i].req1, tbl[i].src1, tbl[i].amt1, tbl[i].rdy);
            #1;
            chk($sformatf("v%0d gnt0", i), {31'd0, gnt0}, {31'd0, tbl[i].g0});
            chk($sformatf("v%0d gnt1", i), {31'd0, gnt1}, {31'd0, tbl[i].g1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d res_vld", i), {31'd0, res_vld}, {31'd0, tbl[i].vld});
            chk($sformatf("v%0d res_id", i),  {31'd0, res_id},  {31'd0, tbl[i].id});
            chk($sformatf("v%0d res", i),     {16'd0, res},     {16'd0, tbl[i].res});
            chk($sformatf("v%0d gcnt0", i),   {24'd0, gcnt0},   {24'd0, tbl[i].c0});
            chk($sformatf("v%0d gcnt1", i),   {24'd0, gcnt1},   {24'd0, tbl[i].c1});
            n_vec++;
        end

        // Saturation: clear, then 260 back-to-back port-0 grants.
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0);
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 16'h0001, 4'd1, 1'b0, 16'h0000, 4'd0, 1'b1);
            @(posedge clk);
            #1;
            if (k == 254) chk("sat gcnt0 at 254", {24'd0, gcnt0}, 32'h0000_00FE);
            if (k == 255) chk("sat gcnt0 at 255", {24'd0, gcnt0}, 32'h0000_00FF);
        end
        chk("sat gcnt0 held", {24'd0, gcnt0}, 32'h0000_00FF);
        chk("sat gcnt1 idle", {24'd0, gcnt1}, 32'h0000_0000);
        chk("sat res_vld",    {31'd0, res_vld}, 32'd1);
        chk("sat res",        {16'd0, res},     32'h0000_0002);
        n_vec++;

        // Reset while FULL with a saturated counter.
        @(negedge clk);
        drive(1'b1, 1'b1, 16'h0001, 4'd1, 1'b1, 16'h0001, 4'd1, 1'b0);
        #1;
        chk("rst gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst gnt1", {31'd0, gnt1}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst res_vld", {31'd0, res_vld}, 32'd0);
        chk("rst gcnt0",   {24'd0, gcnt0},   32'd0);
        chk("rst res",     {16'd0, res},     32'd0);
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
